// File: rtl/led_pkg.sv
// led_pkg: shared constants, duty type and channel-geometry helpers for the LED PWM controller
//   WIDTH_DEF     default duty / frame-counter width
//   CLK_PERIOD_NS nominal period of the 4.1 MHz system clock
//   cw_of         channel-select width for a given channel count
//   ofs_of        per-channel phase offset in counter ticks
package led_pkg;
    localparam int WIDTH_DEF = 12;
    localparam int CLK_PERIOD_NS = 244;
    typedef logic [WIDTH_DEF-1:0] duty_t;
    function automatic int cw_of(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction
    function automatic int ofs_of(input int w, input int ch, input int st);
        return (st != 0) ? (1 << w) / ch : 0;
    endfunction
endpackage

// File: rtl/led_pwm_multi_if.sv
// led_pwm_multi_if: duty-write port of the multi-channel LED PWM controller
//   wr_valid/wr_ready  handshake, transfer when both high at a rising edge
//   wr_ch              target channel
//   wr_data            target duty
//   fade_en            ramp (1) or jump (0), sampled on the commit cycle
interface led_pwm_multi_if import led_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHANNELS = 4
) ();
    localparam int CW = cw_of(CHANNELS);
    logic            wr_valid;
    logic            wr_ready;
    logic [CW-1:0]   wr_ch;
    logic [WIDTH-1:0] wr_data;
    logic            fade_en;
    modport master (output wr_valid, wr_ch, wr_data, fade_en, input wr_ready);
    modport slave  (input wr_valid, wr_ch, wr_data, fade_en, output wr_ready);
endinterface

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one PWM channel with shadow/active duty, frame-boundary commit and optional fade
//   clk, rst      clock, asynchronous active-high reset
//   ph            this channel's phase within the frame
//   commit        high on the last cycle of the frame
//   wr, wr_data   shadow write strobe and value
//   fade_en       ramp active toward shadow by FADE_STEP per commit
//   power         registered PWM output
//   busy          active duty has not yet reached shadow
module led_pwm_chan import led_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FADE_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ph,
    input  logic             commit,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fade_en,
    output logic             power,
    output logic             busy
);
    localparam logic signed [WIDTH:0] STEP = (WIDTH+1)'(FADE_STEP);
    logic [WIDTH-1:0] shadow, active, nxt;
    logic signed [WIDTH:0] d;
    // one extra bit keeps the signed distance exact; a step is taken only when
    // it cannot pass the target, so the ramp never overshoots or wraps
    always_comb begin
        d = $signed({1'b0, shadow}) - $signed({1'b0, active});
        nxt = (!fade_en || (d <= STEP && d >= -STEP)) ? shadow :
              (d > STEP) ? active + STEP[WIDTH-1:0] : active - STEP[WIDTH-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            power  <= 1'b0;
        end else begin
            if (wr) shadow <= wr_data;
            if (commit) active <= nxt;
            power <= ph < active;
        end
    end
    assign busy = active != shadow;
endmodule

// File: rtl/led_pwm_multi.sv
// led_pwm_multi: multi-channel LED PWM with tear-free frame commits, fade and phase stagger
//   clk           system clock
//   globalReset   asynchronous active-high reset
//   bus           duty-write port (slave side)
//   frame_start   high while the frame counter is 0
//   power         registered PWM outputs, one per channel
//   busy          per channel, active duty differs from shadow
module led_pwm_multi import led_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHANNELS = 4,
    parameter int STAGGER = 1,
    parameter int FADE_STEP = 16
) (
    input  logic                clk,
    input  logic                globalReset,
    led_pwm_multi_if.slave      bus,
    output logic                frame_start,
    output logic [CHANNELS-1:0] power,
    output logic [CHANNELS-1:0] busy
);
    localparam int CW = cw_of(CHANNELS);
    localparam int OFS = ofs_of(WIDTH, CHANNELS, STAGGER);
    logic [WIDTH-1:0] cnt;
    logic commit, wr_fire;
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
    // writes are refused on the commit cycle so a shadow update never races the commit
    assign commit = &cnt;
    assign frame_start = cnt == '0;
    assign bus.wr_ready = !commit;
    assign wr_fire = bus.wr_valid && !commit;
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] ph;
        assign ph = cnt + WIDTH'(k * OFS);
        led_pwm_chan #(.WIDTH(WIDTH), .FADE_STEP(FADE_STEP)) u_chan (
            .clk     (clk),
            .rst     (globalReset),
            .ph      (ph),
            .commit  (commit),
            .wr      (wr_fire && (CHANNELS == 1 || bus.wr_ch == CW'(k))),
            .wr_data (bus.wr_data),
            .fade_en (bus.fade_en),
            .power   (power[k]),
            .busy    (busy[k])
        );
    end
endmodule

// File: tb/tb_led_pwm_multi.sv
// tb_led_pwm_multi: directed bench for led_pwm_multi, aligned and staggered instances driven in parallel
module tb_led_pwm_multi;
    import led_pkg::*;
    localparam int N = 4096;
    localparam int MAXC = N - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vld = 1'b0;
    logic [1:0] wch = '0;
    duty_t wdat = '0;
    logic fe = 1'b0;
    logic [3:0] pw [2];
    logic [3:0] bz [2];
    logic fs [2];
    logic rdy [2];

    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    led_pwm_multi_if #(.WIDTH(12), .CHANNELS(4)) if0 ();
    led_pwm_multi_if #(.WIDTH(12), .CHANNELS(4)) if1 ();
    assign if0.wr_valid = vld;
    assign if0.wr_ch = wch;
    assign if0.wr_data = wdat;
    assign if0.fade_en = fe;
    assign if1.wr_valid = vld;
    assign if1.wr_ch = wch;
    assign if1.wr_data = wdat;
    assign if1.fade_en = fe;
    assign rdy[0] = if0.wr_ready;
    assign rdy[1] = if1.wr_ready;

    led_pwm_multi #(.WIDTH(12), .CHANNELS(4), .STAGGER(0), .FADE_STEP(16)) dut0 (
        .clk(clk), .globalReset(rst), .bus(if0), .frame_start(fs[0]), .power(pw[0]), .busy(bz[0]));
    led_pwm_multi #(.WIDTH(12), .CHANNELS(4), .STAGGER(1), .FADE_STEP(16)) dut1 (
        .clk(clk), .globalReset(rst), .bus(if1), .frame_start(fs[1]), .power(pw[1]), .busy(bz[1]));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    // reference model: frame position, shadow and active duty per instance/channel
    int ofs [2] = '{0, N / 4};
    int m_cnt = 0;
    int m_sh [2][4];
    int m_act [2][4];
    int m_pw [2][4];

    task automatic model_step();
        int diff;
        if (rst) begin
            m_cnt = 0;
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 4; k++) begin
                    m_sh[d][k] = 0;
                    m_act[d][k] = 0;
                    m_pw[d][k] = 0;
                end
        end else begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 4; k++)
                    m_pw[d][k] = (((m_cnt + k * ofs[d]) % N) < m_act[d][k]) ? 1 : 0;
            if (vld && m_cnt != MAXC)
                for (int d = 0; d < 2; d++) m_sh[d][wch] = int'(wdat);
            if (m_cnt == MAXC)
                for (int d = 0; d < 2; d++)
                    for (int k = 0; k < 4; k++) begin
                        diff = m_sh[d][k] - m_act[d][k];
                        if (!fe || (diff <= 16 && diff >= -16)) m_act[d][k] = m_sh[d][k];
                        else if (diff > 0) m_act[d][k] += 16;
                        else m_act[d][k] -= 16;
                    end
            m_cnt = (m_cnt + 1) % N;
        end
    endtask

    // per-frame statistics gathered from the DUT outputs
    int acc_cnt [2][4];
    int acc_first [2][4];
    int acc_pop [2];
    int last_cnt [2][4];
    int last_first [2][4];
    int last_pop [2];
    int frames = 0;

    initial begin
        int e, b, idx;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            for (int d = 0; d < 2; d++) begin
                e = 0;
                b = 0;
                for (int k = 0; k < 4; k++) begin
                    e |= m_pw[d][k] << k;
                    b |= ((m_sh[d][k] != m_act[d][k]) ? 1 : 0) << k;
                end
                chk($sformatf("power%0d", d), int'(pw[d]), e);
                chk($sformatf("busy%0d", d), int'(bz[d]), b);
                chk($sformatf("frame_start%0d", d), int'(fs[d]), (m_cnt == 0) ? 1 : 0);
                chk($sformatf("wr_ready%0d", d), int'(rdy[d]), (m_cnt != MAXC) ? 1 : 0);
            end
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    acc_pop[d] = 0;
                    for (int k = 0; k < 4; k++) begin
                        acc_cnt[d][k] = 0;
                        acc_first[d][k] = 0;
                    end
                end
            end else begin
                idx = (m_cnt == 0) ? N : m_cnt;
                for (int d = 0; d < 2; d++) begin
                    if ($countones(pw[d]) > acc_pop[d]) acc_pop[d] = $countones(pw[d]);
                    for (int k = 0; k < 4; k++)
                        if (pw[d][k]) begin
                            acc_cnt[d][k]++;
                            if (acc_first[d][k] == 0) acc_first[d][k] = idx;
                        end
                end
                if (m_cnt == 0) begin
                    for (int d = 0; d < 2; d++) begin
                        last_pop[d] = acc_pop[d];
                        acc_pop[d] = 0;
                        for (int k = 0; k < 4; k++) begin
                            last_cnt[d][k] = acc_cnt[d][k];
                            last_first[d][k] = acc_first[d][k];
                            acc_cnt[d][k] = 0;
                            acc_first[d][k] = 0;
                        end
                    end
                    frames++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_frame();
        int f = frames;
        int n = 0;
        while (frames == f && n < 2 * N) begin
            cyc(1);
            n++;
        end
        chk("frame_wait", (frames != f) ? 1 : 0, 1);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m_cnt != v && n < 2 * N) begin
            cyc(1);
            n++;
        end
        chk("cnt_wait", m_cnt, v);
    endtask

    task automatic wr(input int ch, input int data);
        int n = 0;
        vld = 1'b1;
        wch = 2'(ch);
        wdat = duty_t'(data);
        while (!if0.wr_ready && n < 8) begin
            cyc(1);
            n++;
        end
        chk("wr_accept", (n < 8) ? 1 : 0, 1);
        cyc(1);
        vld = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        #1;
        chk("rel_frame_start", int'(fs[0]), 1);
        chk("rel_wr_ready", int'(rdy[0]), 1);
        // reset mid-frame while ch0 runs duty 100
        wr(0, 100);
        wait_frame();
        chk("f0_ch0", last_cnt[0][0], 0);
        wait_frame();
        chk("f1_ch0", last_cnt[0][0], 100);
        chk("f1_ch0_stag", last_cnt[1][0], 100);
        cyc(50);
        chk("pre_rst_ch0", int'(pw[0][0]), 1);
        rst = 1'b1;
        #1;
        chk("rst_power0", int'(pw[0]), 0);
        chk("rst_power1", int'(pw[1]), 0);
        chk("rst_busy", int'(bz[0]), 0);
        cyc(3);
        rst = 1'b0;
        #1;
        chk("post_rst_frame_start", int'(fs[0]), 1);
        wait_frame();
        chk("post_rst_ch0", last_cnt[0][0], 0);
        // duty extremes
        wr(0, 0);
        wr(1, MAXC);
        wr(2, 1000);
        wait_frame();
        chk("pre_commit_ch1", last_cnt[0][1], 0);
        wait_frame();
        chk("ext_ch0", last_cnt[0][0], 0);
        chk("ext_ch1", last_cnt[0][1], MAXC);
        chk("ext_ch1_first", last_first[0][1], 1);
        chk("ext_ch2", last_cnt[0][2], 1000);
        // frame atomicity, then a write presented on the commit cycle
        cyc(100);
        wr(2, 2000);
        cyc(100);
        wr(2, 3000);
        wait_cnt(MAXC);
        vld = 1'b1;
        wch = 2'd3;
        wdat = duty_t'(500);
        chk("ready_at_max", int'(if0.wr_ready), 0);
        cyc(1);
        chk("ready_at_zero", int'(if0.wr_ready), 1);
        cyc(1);
        vld = 1'b0;
        chk("atom_old_ch2", last_cnt[0][2], 1000);
        chk("hs_busy3", int'(bz[0][3]), 1);
        wait_frame();
        chk("atom_new_ch2", last_cnt[0][2], 3000);
        chk("hs_ch3_pending", last_cnt[0][3], 0);
        wait_frame();
        chk("hs_ch3", last_cnt[0][3], 500);
        // fade up 0 -> 40 then down 40 -> 5
        fe = 1'b1;
        wr(0, 40);
        wait_frame();
        chk("fade_start", last_cnt[0][0], 0);
        wait_frame();
        chk("fade_up1", last_cnt[0][0], 16);
        chk("fade_busy1", int'(bz[0][0]), 1);
        wait_frame();
        chk("fade_up2", last_cnt[0][0], 32);
        chk("fade_busy_done", int'(bz[0][0]), 0);
        wr(0, 5);
        wait_frame();
        chk("fade_up3", last_cnt[0][0], 40);
        wait_frame();
        chk("fade_dn1", last_cnt[0][0], 24);
        wait_frame();
        chk("fade_dn2", last_cnt[0][0], 8);
        wait_frame();
        chk("fade_dn3", last_cnt[0][0], 5);
        chk("fade_dn_busy", int'(bz[0][0]), 0);
        // phase stagger with every channel at a quarter duty
        fe = 1'b0;
        for (int k = 0; k < 4; k++) wr(k, 1024);
        wait_frame();
        wait_frame();
        for (int k = 0; k < 4; k++) chk($sformatf("stag_cnt%0d", k), last_cnt[1][k], 1024);
        chk("stag_first0", last_first[1][0], 1);
        chk("stag_first1", last_first[1][1], 3073);
        chk("stag_first2", last_first[1][2], 2049);
        chk("stag_first3", last_first[1][3], 1025);
        chk("stag_maxpop", last_pop[1], 1);
        chk("aligned_maxpop", last_pop[0], 4);
        cyc(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
